// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the MEM stage: access sizes, FSM states,
// alignment, byte-enable and store-lane replication.
package mem_access_pkg;

  localparam logic [1:0] SzByte = 2'b00;
  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzWord = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } mem_state_e;

  function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SzByte:  is_aligned = 1'b1;
      SzHalf:  is_aligned = ~a[0];
      default: is_aligned = (a == 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SzByte:  byte_en = 4'b0001 << a;
      SzHalf:  byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      SzByte:  lane_data = {4{d[7:0]}};
      SzHalf:  lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack port between the MEM stage (master) and memory (slave).
interface mem_access_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half lane of a read word and sign/zero-extends it.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SzByte:  value = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SzHalf:  value = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage with MEM/WB register: req/ack data-memory access, timeout abort,
// misalignment detection and upstream stall.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         MemtoReg,
  input  logic         RegWrite,
  input  logic [1:0]   size,
  input  logic         uns,
  input  logic [31:0]  Aluout,
  input  logic [31:0]  Wdata,
  input  logic [4:0]   rd,
  output logic         mem_stall,
  mem_access_if.master dm,
  output logic         MemtoReg_out,
  output logic         RegWrite_out,
  output logic [31:0]  Rdata_out,
  output logic [31:0]  Aluout_out,
  output logic [4:0]   rd_out,
  output logic         addr_err,
  output logic         bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  mem_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_op, aligned, access, abort;
  logic [31:0]     load_value;

  logic        m2r_d, rw_d, aerr_d, berr_d;
  logic [31:0] rdata_d;

  load_align u_load_align (
    .rdata   (dm.dm_rdata),
    .addr_lo (Aluout[1:0]),
    .size    (size),
    .uns     (uns),
    .value   (load_value)
  );

  assign mem_op  = in_valid & (MemRead | MemWrite);
  assign aligned = is_aligned(size, Aluout[1:0]);
  assign access  = mem_op & aligned;
  assign abort   = (state_q == StWait) && (cnt_q == CntW'(TIMEOUT - 1));

  // Gated by reset so the request drops the moment reset asserts.
  assign dm.dm_req   = reset & access & ~abort;
  assign mem_stall   = reset & access & ~dm.dm_ack & ~abort;
  assign dm.dm_we    = MemWrite & ~MemRead;
  assign dm.dm_addr  = {Aluout[31:2], 2'b00};
  assign dm.dm_be    = byte_en(size, Aluout[1:0]);
  assign dm.dm_wdata = lane_data(size, Wdata);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (access && !dm.dm_ack) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (dm.dm_ack || abort || !access) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    rw_d    = in_valid & RegWrite;
    m2r_d   = in_valid & MemtoReg;
    rdata_d = '0;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    if (mem_op) begin
      if (!aligned) begin
        rw_d   = 1'b0;
        m2r_d  = 1'b0;
        aerr_d = 1'b1;
      end else if (abort) begin
        rw_d   = 1'b0;
        m2r_d  = 1'b0;
        berr_d = 1'b1;
      end else if (!dm.dm_ack) begin
        // Bubble while the access is outstanding.
        rw_d  = 1'b0;
        m2r_d = 1'b0;
      end else if (MemRead) begin
        rdata_d = load_value;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      MemtoReg_out <= 1'b0;
      RegWrite_out <= 1'b0;
      Rdata_out    <= '0;
      Aluout_out   <= '0;
      rd_out       <= '0;
      addr_err     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      MemtoReg_out <= m2r_d;
      RegWrite_out <= rw_d;
      Rdata_out    <= rdata_d;
      Aluout_out   <= Aluout;
      rd_out       <= rd;
      addr_err     <= aerr_d;
      bus_err      <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, loads/stores, misalignment,
// timeout abort and reset during an outstanding access.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, MemRead, MemWrite, MemtoReg, RegWrite, uns;
  logic [1:0]  size;
  logic [31:0] Aluout, Wdata;
  logic [4:0]  rd;
  logic        mem_stall;
  logic        MemtoReg_out, RegWrite_out, addr_err, bus_err;
  logic [31:0] Rdata_out, Aluout_out;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;
  int n;

  mem_access_if dm ();

  mem_access #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .size         (size),
    .uns          (uns),
    .Aluout       (Aluout),
    .Wdata        (Wdata),
    .rd           (rd),
    .mem_stall    (mem_stall),
    .dm           (dm.master),
    .MemtoReg_out (MemtoReg_out),
    .RegWrite_out (RegWrite_out),
    .Rdata_out    (Rdata_out),
    .Aluout_out   (Aluout_out),
    .rd_out       (rd_out),
    .addr_err     (addr_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
    RegWrite = 1'b0; uns = 1'b0; size = 2'b10; Aluout = '0; Wdata = '0; rd = '0;
    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
  endtask

  task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [4:0] r);
    clear_inputs();
    in_valid = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1;
    Aluout = a; size = sz; uns = u; rd = r;
  endtask

  initial begin
    // Reset with a load already presented: request must stay low.
    reset = 1'b0;
    set_load(32'h100, 2'b10, 1'b0, 5'd3);
    #12;
    chk("rst_dm_req", {31'b0, dm.dm_req}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_regwrite", {31'b0, RegWrite_out}, 32'd0);
    chk("rst_aluout", Aluout_out, 32'd0);
    chk("rst_rdata", Rdata_out, 32'd0);
    chk("rst_rd", {27'b0, rd_out}, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;

    // ALU op pass-through.
    tick();
    clear_inputs();
    in_valid = 1'b1; RegWrite = 1'b1; rd = 5'd5; Aluout = 32'h1234;
    #1;
    chk("alu_stall", {31'b0, mem_stall}, 32'd0);
    chk("alu_dm_req", {31'b0, dm.dm_req}, 32'd0);
    tick();
    chk("alu_regwrite", {31'b0, RegWrite_out}, 32'd1);
    chk("alu_aluout", Aluout_out, 32'h1234);
    chk("alu_rd", {27'b0, rd_out}, 32'd5);

    // LB signed at 0x103, acked in the fourth request cycle.
    set_load(32'h103, 2'b00, 1'b0, 5'd7);
    #1;
    chk("lb_dm_req", {31'b0, dm.dm_req}, 32'd1);
    chk("lb_dm_we", {31'b0, dm.dm_we}, 32'd0);
    chk("lb_dm_be", {28'b0, dm.dm_be}, 32'b1000);
    chk("lb_dm_addr", dm.dm_addr, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", {31'b0, mem_stall}, 32'd1);
      tick();
      chk("lb_bubble", {31'b0, RegWrite_out}, 32'd0);
    end
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h80FF_FF7F;
    #1;
    chk("lb_release", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("lb_rdata", Rdata_out, 32'hFFFF_FF80);
    chk("lb_regwrite", {31'b0, RegWrite_out}, 32'd1);
    chk("lb_memtoreg", {31'b0, MemtoReg_out}, 32'd1);
    chk("lb_rd", {27'b0, rd_out}, 32'd7);

    // LHU at 0x102 with zero-wait ack.
    set_load(32'h102, 2'b01, 1'b1, 5'd9);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'hBEEF_1234;
    #1;
    chk("lhu_dm_req", {31'b0, dm.dm_req}, 32'd1);
    chk("lhu_stall", {31'b0, mem_stall}, 32'd0);
    chk("lhu_dm_be", {28'b0, dm.dm_be}, 32'b1100);
    tick();
    chk("lhu_rdata", Rdata_out, 32'h0000_BEEF);

    // LH signed at 0x100 with zero-wait ack.
    set_load(32'h100, 2'b01, 1'b0, 5'd10);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h0000_8001;
    tick();
    chk("lh_rdata", Rdata_out, 32'hFFFF_8001);

    // SB at 0x201.
    clear_inputs();
    in_valid = 1'b1; MemWrite = 1'b1; size = 2'b00; Aluout = 32'h201; Wdata = 32'hAB;
    dm.dm_ack = 1'b1;
    #1;
    chk("sb_dm_we", {31'b0, dm.dm_we}, 32'd1);
    chk("sb_dm_be", {28'b0, dm.dm_be}, 32'b0010);
    chk("sb_dm_wdata", dm.dm_wdata, 32'hABAB_ABAB);
    chk("sb_dm_addr", dm.dm_addr, 32'h200);
    tick();
    chk("sb_rdata", Rdata_out, 32'd0);
    chk("sb_regwrite", {31'b0, RegWrite_out}, 32'd0);

    // SH at 0x202 replicates the halfword.
    clear_inputs();
    in_valid = 1'b1; MemWrite = 1'b1; size = 2'b01; Aluout = 32'h202; Wdata = 32'h5566_7788;
    dm.dm_ack = 1'b1;
    #1;
    chk("sh_dm_wdata", dm.dm_wdata, 32'h7788_7788);
    chk("sh_dm_be", {28'b0, dm.dm_be}, 32'b1100);
    tick();

    // Misaligned LW.
    set_load(32'h102, 2'b10, 1'b0, 5'd4);
    #1;
    chk("lw_mis_dm_req", {31'b0, dm.dm_req}, 32'd0);
    chk("lw_mis_stall", {31'b0, mem_stall}, 32'd0);
    tick();
    chk("lw_mis_addr_err", {31'b0, addr_err}, 32'd1);
    chk("lw_mis_regwrite", {31'b0, RegWrite_out}, 32'd0);
    clear_inputs();
    tick();
    chk("addr_err_pulse", {31'b0, addr_err}, 32'd0);

    // Timeout: no ack ever.
    set_load(32'h300, 2'b10, 1'b0, 5'd6);
    #1;
    n = 0;
    while (mem_stall === 1'b1 && n < 40) begin
      n++;
      @(posedge clk);
      #2;
    end
    chk("to_stall_cycles", n, 32'd16);
    chk("to_dm_req_drop", {31'b0, dm.dm_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_bus_err", {31'b0, bus_err}, 32'd1);
    chk("to_regwrite", {31'b0, RegWrite_out}, 32'd0);
    clear_inputs();
    tick();
    chk("bus_err_pulse", {31'b0, bus_err}, 32'd0);

    // Reset while waiting on an access.
    set_load(32'h400, 2'b10, 1'b0, 5'd8);
    tick();
    chk("wait_stall", {31'b0, mem_stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstw_dm_req", {31'b0, dm.dm_req}, 32'd0);
    chk("rstw_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstw_aluout", Aluout_out, 32'd0);
    chk("rstw_rd", {27'b0, rd_out}, 32'd0);
    tick();
    chk("rstw_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rstw_addr_err", {31'b0, addr_err}, 32'd0);
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_regwrite", {31'b0, RegWrite_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
